// File: rtl/vdf_norm_pkg.sv
// Shared constants and types for the column carry normalizer that follows the
// squarer's column adder.
package vdf_norm_pkg;

   localparam int DEFAULT_SUM_W   = 42;
   localparam int DEFAULT_DIGIT_W = 17;

   typedef enum logic [0:0] {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } norm_state_t;

   function automatic int carry_width(input int sum_w, input int digit_w);
      return sum_w + 1 - digit_w;
   endfunction

   // Flush digit count is fixed, so every frame is exactly columns + this many digits long.
   function automatic int flush_digits(input int sum_w, input int digit_w);
      int cw;
      cw = carry_width(sum_w, digit_w);
      return (cw + digit_w - 1) / digit_w;
   endfunction

endpackage

// File: rtl/column_carry_normalizer.sv
// Turns a stream of wide column sums (LSB column first) into fixed-width digits,
// propagating the carry between columns and flushing it after the last column.
module column_carry_normalizer
   import vdf_norm_pkg::*;
#(
   parameter int SUM_W   = DEFAULT_SUM_W,
   parameter int DIGIT_W = DEFAULT_DIGIT_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [SUM_W-1:0]   in_sum,
   input  logic               in_last,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DIGIT_W-1:0] out_digit,
   output logic               out_last
);

   localparam int CARRY_W      = carry_width(SUM_W, DIGIT_W);
   localparam int FLUSH_DIGITS = flush_digits(SUM_W, DIGIT_W);
   localparam int FCNT_W       = (FLUSH_DIGITS > 1) ? $clog2(FLUSH_DIGITS) : 1;

   norm_state_t                state_r, state_s;
   logic [CARRY_W-1:0]         carry_r, carry_s;
   logic [FCNT_W-1:0]          flush_cnt_r, flush_cnt_s;
   logic                       out_valid_r, out_valid_s;
   logic [DIGIT_W-1:0]         out_digit_r, out_digit_s;
   logic                       out_last_r, out_last_s;

   logic                       out_free_s;
   logic                       in_fire_s;
   logic [SUM_W:0]             sum_ext_s;
   logic [CARRY_W+DIGIT_W-1:0] flush_pad_s;

   assign out_free_s = ~out_valid_r | out_ready;
   assign in_ready   = (state_r == RUN) & out_free_s;
   assign in_fire_s  = in_valid & in_ready;

   // The carry is always below 2^CARRY_W, so this sum cannot overflow SUM_W+1 bits.
   assign sum_ext_s   = {1'b0, in_sum} + {{DIGIT_W{1'b0}}, carry_r};
   assign flush_pad_s = {{DIGIT_W{1'b0}}, carry_r};

   assign out_valid = out_valid_r;
   assign out_digit = out_digit_r;
   assign out_last  = out_last_r;

   // Next-state and next-output decode for the RUN/FLUSH sequencer.
   always_comb begin
      state_s     = state_r;
      carry_s     = carry_r;
      flush_cnt_s = flush_cnt_r;
      out_valid_s = out_valid_r;
      out_digit_s = out_digit_r;
      out_last_s  = out_last_r;
      case (state_r)
         RUN: begin
            if (in_fire_s) begin
               out_digit_s = sum_ext_s[DIGIT_W-1:0];
               out_last_s  = 1'b0;
               out_valid_s = 1'b1;
               carry_s     = sum_ext_s[SUM_W:DIGIT_W];
               if (in_last) begin
                  state_s     = FLUSH;
                  flush_cnt_s = {FCNT_W{1'b0}};
               end else begin
                  state_s     = RUN;
               end
            end else if (out_valid_r & out_ready) begin
               out_valid_s = 1'b0;
            end else begin
               out_valid_s = out_valid_r;
            end
         end
         FLUSH: begin
            if (out_free_s) begin
               out_digit_s = flush_pad_s[DIGIT_W-1:0];
               out_valid_s = 1'b1;
               carry_s     = flush_pad_s[CARRY_W+DIGIT_W-1:DIGIT_W];
               flush_cnt_s = flush_cnt_r + FCNT_W'(1);
               // Last flush digit closes the frame and clears state for the next one.
               if (flush_cnt_r == FCNT_W'(FLUSH_DIGITS - 1)) begin
                  out_last_s  = 1'b1;
                  carry_s     = {CARRY_W{1'b0}};
                  flush_cnt_s = {FCNT_W{1'b0}};
                  state_s     = RUN;
               end else begin
                  out_last_s  = 1'b0;
               end
            end else begin
               flush_cnt_s = flush_cnt_r;
            end
         end
         default: begin
            state_s     = RUN;
            carry_s     = {CARRY_W{1'b0}};
            flush_cnt_s = {FCNT_W{1'b0}};
            out_valid_s = 1'b0;
            out_last_s  = 1'b0;
         end
      endcase
   end

   // State, carry and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= RUN;
         carry_r     <= {CARRY_W{1'b0}};
         flush_cnt_r <= {FCNT_W{1'b0}};
         out_valid_r <= 1'b0;
         out_digit_r <= {DIGIT_W{1'b0}};
         out_last_r  <= 1'b0;
      end else begin
         state_r     <= state_s;
         carry_r     <= carry_s;
         flush_cnt_r <= flush_cnt_s;
         out_valid_r <= out_valid_s;
         out_digit_r <= out_digit_s;
         out_last_r  <= out_last_s;
      end
   end

endmodule

// File: tb/tb_column_carry_normalizer.sv
// Scoreboard bench for column_carry_normalizer at default widths (SUM_W=42, DIGIT_W=17).
module tb_column_carry_normalizer;

   localparam int NDIG = 17;
   localparam int BIGW = 2304;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [41:0] in_sum;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [16:0] out_digit;
   logic        out_last;

   int          errors = 0;
   int          checks = 0;
   int          dig_cnt = 0;
   bit          rand_ready = 1'b0;
   logic [17:0] exp_q[$];
   int          len_q[$];
   logic [41:0] frame_q[$];

   column_carry_normalizer dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sum    (in_sum),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_digit (out_digit),
      .out_last  (out_last)
   );

   always #5 clk = ~clk;

   task automatic monitor();
      logic [17:0] e;
      int          l;
      forever begin
         @(negedge clk);
         if (reset) begin
            dig_cnt = 0;
         end else if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL digit: got last=%b digit=%h, required no digit", out_last, out_digit);
            end else begin
               e = exp_q.pop_front();
               if ({out_last, out_digit} !== e) begin
                  errors++;
                  $display("FAIL digit: got last=%b digit=%h, required last=%b digit=%h",
                           out_last, out_digit, e[17], e[16:0]);
               end
            end
            dig_cnt++;
            if (out_last === 1'b1) begin
               checks++;
               l = (len_q.size() == 0) ? -1 : len_q.pop_front();
               if (dig_cnt != l) begin
                  errors++;
                  $display("FAIL frame_len: got %0d digits, required %0d", dig_cnt, l);
               end
               dig_cnt = 0;
            end
         end
      end
   endtask

   task automatic ready_rand();
      forever begin
         @(posedge clk);
         #1;
         if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      end
   endtask

   // Expected digits from the big-integer value sum(in_sum[i] << 17*i).
   task automatic push_model();
      logic [BIGW-1:0] big;
      logic [BIGW-1:0] tmp;
      int              n;
      n   = frame_q.size();
      big = '0;
      for (int i = 0; i < n; i++) begin
         tmp       = '0;
         tmp[41:0] = frame_q[i];
         big       = big + (tmp << (NDIG * i));
      end
      for (int k = 0; k < n + 2; k++) exp_q.push_back({(k == n + 1), big[NDIG*k +: NDIG]});
      len_q.push_back(n + 2);
   endtask

   task automatic drive_col(input logic [41:0] s, input bit last, input bit rand_valid);
      int g;
      bit done;
      if (rand_valid) begin
         while ($urandom_range(0, 2) == 0) begin
            in_valid = 1'b0;
            in_last  = 1'($urandom_range(0, 1));
            in_sum   = 42'($urandom());
            @(posedge clk);
            #1;
         end
      end
      in_valid = 1'b1;
      in_sum   = s;
      in_last  = last;
      g        = 0;
      done     = 1'b0;
      while (!done && g < 2000) begin
         @(negedge clk);
         done = (in_ready === 1'b1);
         @(posedge clk);
         #1;
         g++;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL in_accept: column %h not accepted after %0d cycles, required acceptance", s, g);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_frame(input bit rand_valid);
      for (int i = 0; i < frame_q.size(); i++) drive_col(frame_q[i], (i == frame_q.size() - 1), rand_valid);
   endtask

   task automatic wait_drain();
      int g;
      g = 0;
      while (exp_q.size() != 0 && g < 5000) begin
         @(posedge clk);
         #1;
         g++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d digits outstanding, required 0", exp_q.size());
      end
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      in_sum    = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({out_valid, out_last, out_digit} !== 19'h0) begin
         errors++;
         $display("FAIL reset_out: got valid=%b last=%b digit=%h, required 0 0 0", out_valid, out_last, out_digit);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready: got %b, required 1", in_ready);
      end
      @(posedge clk);
      #1;
      in_last = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL idle_last: got in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
      end
      @(posedge clk);
      #1;
      in_last = 1'b0;
   endtask

   task automatic test_basic();
      frame_q = '{42'h1FFFF, 42'h1, 42'h0};
      exp_q.push_back({1'b0, 17'h1FFFF});
      exp_q.push_back({1'b0, 17'h00001});
      exp_q.push_back({1'b0, 17'h00000});
      exp_q.push_back({1'b0, 17'h00000});
      exp_q.push_back({1'b1, 17'h00000});
      len_q.push_back(5);
      send_frame(1'b0);
      wait_drain();
   endtask

   task automatic test_all_ones();
      frame_q = '{42'h3FF_FFFF_FFFF};
      exp_q.push_back({1'b0, 17'h1FFFF});
      exp_q.push_back({1'b0, 17'h1FFFF});
      exp_q.push_back({1'b1, 17'h000FF});
      len_q.push_back(3);
      send_frame(1'b0);
      wait_drain();
   endtask

   task automatic test_stall();
      frame_q = '{42'h12345, 42'h3FF_FFFF_FFFF, 42'h1};
      push_model();
      drive_col(42'h12345, 1'b0, 1'b0);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_sum    = 42'h3FF_FFFF_FFFF;
      in_last   = 1'b0;
      repeat (5) begin
         @(negedge clk);
         checks++;
         if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_in_ready: got %b, required 0", in_ready);
         end
         checks++;
         if (out_valid !== 1'b1 || out_digit !== 17'h12345) begin
            errors++;
            $display("FAIL stall_hold: got valid=%b digit=%h, required 1 12345", out_valid, out_digit);
         end
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      drive_col(42'h3FF_FFFF_FFFF, 1'b0, 1'b0);
      drive_col(42'h1, 1'b1, 1'b0);
      wait_drain();
   endtask

   task automatic test_back_to_back();
      frame_q = '{42'h3FF_FFFF_FFFF};
      push_model();
      send_frame(1'b0);
      frame_q = '{42'h2A_BCDE_1234, 42'h3FF_FFFF_FFFF};
      push_model();
      send_frame(1'b0);
      wait_drain();
   endtask

   task automatic test_reset_in_flush();
      exp_q.push_back({1'b0, 17'h1FFFF});
      exp_q.push_back({1'b0, 17'h1FFFF});
      drive_col(42'h3FF_FFFF_FFFF, 1'b1, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      reset     = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      checks++;
      if ({out_valid, out_last, out_digit} !== 19'h0) begin
         errors++;
         $display("FAIL flush_reset: got valid=%b last=%b digit=%h, required 0 0 0", out_valid, out_last, out_digit);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL flush_reset_digits: %0d expected digits not seen, required 0", exp_q.size());
      end
      out_ready = 1'b1;
      frame_q   = '{42'h12345};
      push_model();
      send_frame(1'b0);
      wait_drain();
   endtask

   task automatic test_random();
      int r;
      int n;
      rand_ready = 1'b1;
      for (int f = 0; f < 6; f++) begin
         n       = (f == 0) ? 130 : $urandom_range(1, 130);
         frame_q = {};
         for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 3);
            if (r == 0)      frame_q.push_back(42'h3FF_FFFF_FFFF);
            else if (r == 1) frame_q.push_back(42'h0);
            else             frame_q.push_back(42'({$urandom(), $urandom()}));
         end
         push_model();
         send_frame(1'b1);
      end
      wait_drain();
      rand_ready = 1'b0;
      out_ready  = 1'b1;
   endtask

   initial begin
      fork
         monitor();
         ready_rand();
         begin
            #1000000;
            $display("FAIL watchdog: simulation time limit reached, required completion");
            $fatal(1, "watchdog");
         end
      join_none
      test_reset();
      test_basic();
      test_all_ones();
      test_stall();
      test_back_to_back();
      test_reset_in_flush();
      test_random();
      repeat (4) @(posedge clk);
      checks++;
      if (exp_q.size() != 0 || len_q.size() != 0) begin
         errors++;
         $display("FAIL leftover: digits=%0d frames=%0d, required 0 0", exp_q.size(), len_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
